// File: rtl/hpf_bias_cal_ctrl.sv
// ============================================================================
// hpf_bias_cal_ctrl
// ----------------------------------------------------------------------------
// Calibration sequencer for the differential AC-coupled high-pass filter pair.
// A successive-approximation search on the bias trim DAC code drives the p/n
// filter outputs towards each other (outp ~= outn), using the offset
// comparator as the decision element.
//
// Sequence per calibration:
//   IDLE -> SHORT  : fast_settle pre-charges the coupling nodes
//   SHORT -> SETTLE: wait for the HPF to settle after a code change
//   SETTLE -> SAMPLE: request a comparator decision (with timeout)
//   SAMPLE -> UPDATE: resolve the current bit, trial-set the next one
//   UPDATE -> SETTLE (more bits) or DONE (all bits resolved)
//   DONE -> IDLE   : result held on trim_code, done/sat flagged
//
// Build option:
//   HPF_CAL_MAJORITY_EN  when defined, each bit decision is the majority of
//                        three comparator handshakes, with cmp_req dropped
//                        for one clock between handshakes. The timeout is
//                        applied to each handshake separately.
//
// Parameters:
//   NBITS          trim code width
//   SHORT_CYCLES   clocks fast_settle is held at the start of a cal (>=1)
//   SETTLE_CYCLES  clocks waited after every code change (>=1)
//   CMP_TIMEOUT    clocks cmp_req may wait for cmp_valid (>=1)
//
// Ports:
//   clk          clock
//   rstb         asynchronous active-low reset
//   start        single-cycle pulse, begins calibration (ignored while busy)
//   abort        synchronous abort, wins over start
//   cmp_valid    comparator decision valid (only looked at while sampling)
//   cmp_dec      comparator decision, 1 = outp > outn (trim too high)
//   cmp_req      comparator sample request
//   fast_settle  shorts HPF output to bias for fast pre-charge
//   trim_code    bias trim DAC code (working code while busy, result after)
//   busy         calibration in progress
//   done         level, high after a successful cal until next start/abort
//   sat          final code is all-zeros or all-ones (valid with done)
//   cal_err      comparator timeout occurred, sticky until next start
// ============================================================================
module hpf_bias_cal_ctrl #(
   parameter int NBITS         = 6,
   parameter int SHORT_CYCLES  = 16,
   parameter int SETTLE_CYCLES = 100,
   parameter int CMP_TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_valid,
   input  logic             cmp_dec,
   output logic             cmp_req,
   output logic             fast_settle,
   output logic [NBITS-1:0] trim_code,
   output logic             busy,
   output logic             done,
   output logic             sat,
   output logic             cal_err
);

   // State encoding
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SHORT  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_UPDATE = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   // One down-counter is shared by SHORT, SETTLE and the comparator timeout,
   // since only one of them is ever running. It is sized for the largest.
   localparam int MAX_AB  = (SHORT_CYCLES > SETTLE_CYCLES) ? SHORT_CYCLES : SETTLE_CYCLES;
   localparam int MAX_CNT = (MAX_AB > CMP_TIMEOUT) ? MAX_AB : CMP_TIMEOUT;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int IW      = (NBITS > 1) ? $clog2(NBITS) : 1;

   // Counters are loaded with N-1 on state entry and the state is left on
   // the clock where they read zero, so each phase lasts exactly N clocks.
   localparam logic [CW-1:0] SHORT_LOAD   = CW'(SHORT_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(CMP_TIMEOUT - 1);

   localparam logic [NBITS-1:0] MIDSCALE  = NBITS'(1) << (NBITS - 1);
   localparam logic [NBITS-1:0] FULLSCALE = '1;
   localparam logic [IW-1:0]    TOP_IDX   = IW'(NBITS - 1);

   logic [2:0]       state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_dn;
   logic             dec_q;
   logic [NBITS-1:0] code_upd;
   logic             sat_next;

`ifdef HPF_CAL_MAJORITY_EN
   // Majority-vote bookkeeping: handshake number within the current bit,
   // count of '1' decisions so far, and the one-clock request gap.
   logic [1:0]       hs;
   logic [1:0]       votes;
   logic             gap;
   logic             maj_dec;

   // With two votes already in, the third decision only matters on a tie.
   assign maj_dec = (votes == 2'd2) || ((votes == 2'd1) && cmp_dec);
`endif

   assign idx_dn = idx - 1'b1;

   // SAR step: a '1' decision means the trial bit pushed the output too
   // high, so it is removed; the next lower bit is then trial-set.
   always_comb begin
      code_upd = trim_code;
      if (dec_q) begin
         code_upd[idx] = 1'b0;
      end
      if (idx != '0) begin
         code_upd[idx_dn] = 1'b1;
      end
   end

   assign sat_next = (trim_code == '0) || (trim_code == FULLSCALE);

   // Main sequencer. Abort is evaluated before the state case so it wins
   // over start and over every in-flight phase; cal_err is intentionally
   // left untouched by abort so a timeout report survives until next start.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state       <= S_IDLE;
         cnt         <= '0;
         idx         <= '0;
         dec_q       <= 1'b0;
         cmp_req     <= 1'b0;
         fast_settle <= 1'b0;
         trim_code   <= MIDSCALE;
         busy        <= 1'b0;
         done        <= 1'b0;
         sat         <= 1'b0;
         cal_err     <= 1'b0;
`ifdef HPF_CAL_MAJORITY_EN
         hs          <= '0;
         votes       <= '0;
         gap         <= 1'b0;
`endif
      end else if (abort) begin
         state       <= S_IDLE;
         cmp_req     <= 1'b0;
         fast_settle <= 1'b0;
         trim_code   <= MIDSCALE;
         busy        <= 1'b0;
         done        <= 1'b0;
         sat         <= 1'b0;
`ifdef HPF_CAL_MAJORITY_EN
         hs          <= '0;
         votes       <= '0;
         gap         <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  trim_code   <= MIDSCALE;
                  idx         <= TOP_IDX;
                  busy        <= 1'b1;
                  fast_settle <= 1'b1;
                  done        <= 1'b0;
                  sat         <= 1'b0;
                  cal_err     <= 1'b0;
                  cnt         <= SHORT_LOAD;
                  state       <= S_SHORT;
               end
            end

            S_SHORT: begin
               if (cnt == '0) begin
                  fast_settle <= 1'b0;
                  cnt         <= SETTLE_LOAD;
                  state       <= S_SETTLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_SETTLE: begin
               if (cnt == '0) begin
                  cmp_req <= 1'b1;
                  cnt     <= TIMEOUT_LOAD;
                  state   <= S_SAMPLE;
`ifdef HPF_CAL_MAJORITY_EN
                  hs      <= '0;
                  votes   <= '0;
                  gap     <= 1'b0;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_SAMPLE: begin
`ifdef HPF_CAL_MAJORITY_EN
               // During the gap cmp_valid is ignored and the timeout is not
               // running; the request is re-raised with a fresh timeout.
               if (gap) begin
                  gap     <= 1'b0;
                  cmp_req <= 1'b1;
                  cnt     <= TIMEOUT_LOAD;
               end else if (cmp_valid) begin
                  cmp_req <= 1'b0;
                  if (hs == 2'd2) begin
                     dec_q <= maj_dec;
                     state <= S_UPDATE;
                  end else begin
                     votes <= votes + {1'b0, cmp_dec};
                     hs    <= hs + 1'b1;
                     gap   <= 1'b1;
                  end
               end else if (cnt == '0) begin
                  cal_err   <= 1'b1;
                  busy      <= 1'b0;
                  cmp_req   <= 1'b0;
                  trim_code <= MIDSCALE;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
`else
               // A decision arriving on the final timeout clock still counts.
               if (cmp_valid) begin
                  cmp_req <= 1'b0;
                  dec_q   <= cmp_dec;
                  state   <= S_UPDATE;
               end else if (cnt == '0) begin
                  cal_err   <= 1'b1;
                  busy      <= 1'b0;
                  cmp_req   <= 1'b0;
                  trim_code <= MIDSCALE;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
`endif
            end

            S_UPDATE: begin
               trim_code <= code_upd;
               if (idx != '0) begin
                  idx   <= idx_dn;
                  cnt   <= SETTLE_LOAD;
                  state <= S_SETTLE;
               end else begin
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               sat   <= sat_next;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hpf_bias_cal_ctrl.sv
// ============================================================================
// tb_hpf_bias_cal_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for hpf_bias_cal_ctrl. A comparator model answers each
// cmp_req after a programmable delay, using a decision rule chosen per test.
// The expected code trajectory and final code come from a plain-arithmetic
// SAR reference; latency expectations come from the phase lengths.
// ============================================================================
module tb_hpf_bias_cal_ctrl;

   localparam int NB      = 6;
   localparam int SHORT   = 16;
   localparam int SETTLE  = 100;
   localparam int TIMEOUT = 255;
   localparam int BUDGET  = 5000;
`ifdef HPF_CAL_MAJORITY_EN
   localparam int HS = 3;
`else
   localparam int HS = 1;
`endif

   logic          clk;
   logic          rstb;
   logic          start;
   logic          abort;
   logic          cmp_valid;
   logic          cmp_dec;
   logic          cmp_req;
   logic          fast_settle;
   logic [NB-1:0] trim_code;
   logic          busy;
   logic          done;
   logic          sat;
   logic          cal_err;

   int checks = 0;
   int errors = 0;

   // Comparator model controls: 0 = threshold, 1 = always 1, 2 = always 0,
   // 3 = never answer, 4 = noisy 1,0,1 on first bit then threshold.
   int cmp_mode  = 0;
   int cmp_thr   = 37;
   int k_lat     = 2;
   bit noise     = 1'b0;
   int req_cnt   = 0;
   int req_high  = 0;
   int handshakes = 0;
   int seen[$];
   int exp_q[$];

   hpf_bias_cal_ctrl #(
      .NBITS(NB),
      .SHORT_CYCLES(SHORT),
      .SETTLE_CYCLES(SETTLE),
      .CMP_TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rstb(rstb),
      .start(start),
      .abort(abort),
      .cmp_valid(cmp_valid),
      .cmp_dec(cmp_dec),
      .cmp_req(cmp_req),
      .fast_settle(fast_settle),
      .trim_code(trim_code),
      .busy(busy),
      .done(done),
      .sat(sat),
      .cal_err(cal_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Decision rule of the modelled analog front end for a given trim code.
   function automatic bit decide(input int code);
      logic [2:0] pat;
      pat = 3'b101;
      case (cmp_mode)
         1:       return 1'b1;
         2:       return 1'b0;
         4:       return (handshakes < 3) ? pat[handshakes] : (code > cmp_thr);
         default: return code > cmp_thr;
      endcase
   endfunction

   // Plain SAR reference: trial-set each bit from MSB down, keep it unless
   // the front end reports the output too high. Fills exp_q with the trial
   // codes the comparator should see and returns the final code.
   function automatic int sarRef(input int mode, input int thr);
      int  c;
      bit  d;
      c = 0;
      exp_q.delete();
      for (int i = NB - 1; i >= 0; i--) begin
         c = c | (1 << i);
         exp_q.push_back(c);
         case (mode)
            1:       d = 1'b1;
            2:       d = 1'b0;
            4:       d = (i == NB - 1) ? 1'b1 : (c > thr);
            default: d = c > thr;
         endcase
         if (d) c = c & ~(1 << i);
      end
      return c;
   endfunction

   function automatic int perBit(input int k);
`ifdef HPF_CAL_MAJORITY_EN
      return SETTLE + 3 * (k + 1) + 2 + 1;
`else
      return SETTLE + k + 2;
`endif
   endfunction

   // Comparator model: answers k clocks after cmp_req rises (the answer is
   // sampled by the DUT on the following edge). Optionally toggles
   // cmp_valid/cmp_dec randomly while no request is pending.
   initial begin
      cmp_valid = 1'b0;
      cmp_dec   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cmp_req) begin
            req_high++;
            req_cnt++;
            if (cmp_mode != 3 && req_cnt == k_lat + 1) begin
               cmp_dec = decide(int'(trim_code));
               seen.push_back(int'(trim_code));
               handshakes++;
               cmp_valid = 1'b1;
            end else begin
               cmp_valid = 1'b0;
               cmp_dec   = 1'b0;
            end
         end else begin
            req_cnt = 0;
            if (noise) begin
               cmp_valid = 1'($urandom_range(0, 1));
               cmp_dec   = 1'($urandom_range(0, 1));
            end else begin
               cmp_valid = 1'b0;
               cmp_dec   = 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Runs one full calibration with the given comparator model and returns
   // the number of clocks from the start-sampling edge to done rising.
   task automatic applyStimulus(input int mode, input int thr, input int k,
                                input bit noisy, input bit poke_start, output int lat);
      bit got;
      cmp_mode = mode;
      cmp_thr  = thr;
      k_lat    = k;
      noise    = noisy;
      seen.delete();
      handshakes = 0;
      req_high   = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
         @(posedge clk); #1;
         lat++;
         start = (poke_start && lat == 50);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      noise = 1'b0;
      if (!got) checkOutput("cal_done_wait", 32'd0, 32'd1);
   endtask

   // Runs a calibration and checks result, flags, latency and trajectory.
   task automatic runCal(input string tag, input int mode, input int thr, input int k,
                         input bit noisy, input bit poke_start);
      int lat;
      int expc;
      expc = sarRef(mode, thr);
      applyStimulus(mode, thr, k, noisy, poke_start, lat);
      $display("[TB] %s: thr=%0d k=%0d code=%0d latency=%0d", tag, thr, k, trim_code, lat);
      checkOutput({tag, "_latency"}, lat, 1 + SHORT + NB * perBit(k));
      checkOutput({tag, "_code"}, 32'(trim_code), expc);
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_sat"}, 32'(sat), 32'((expc == 0) || (expc == (1 << NB) - 1)));
      checkOutput({tag, "_cal_err"}, 32'(cal_err), 32'd0);
      checkOutput({tag, "_handshakes"}, handshakes, NB * HS);
      for (int i = 0; i < seen.size() && i < NB * HS; i++) begin
         checkOutput({tag, "_code_seq"}, seen[i], exp_q[i / HS]);
      end
   endtask

   initial begin
      int wait_n;
      bit ok;

      rstb  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_trim", 32'(trim_code), 32'd32);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_fast", 32'(fast_settle), 32'd0);
      checkOutput("rst_req", 32'(cmp_req), 32'd0);
      rstb = 1'b1;
      @(posedge clk); #1;

      // First clock after start: pre-charge active, code at midscale.
      cmp_mode = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_fast", 32'(fast_settle), 32'd1);
      checkOutput("start_trim", 32'(trim_code), 32'd32);
      repeat (SHORT - 1) @(posedge clk);
      #1;
      checkOutput("short_hold", 32'(fast_settle), 32'd1);
      @(posedge clk); #1;
      checkOutput("short_end", 32'(fast_settle), 32'd0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;

      // Directed target and saturation cases.
      runCal("target37", 0, 37, 2, 1'b0, 1'b0);
      runCal("all_ones_dec", 1, 0, 2, 1'b0, 1'b0);
      runCal("all_zero_dec", 2, 0, 2, 1'b0, 1'b0);

      // Randomized thresholds and response delays; one run with cmp_valid
      // noise outside requests, one with start pulsed mid-cal.
      for (int r = 0; r < 4; r++) begin
         runCal("random", 0, int'($urandom_range(0, 63)), int'($urandom_range(1, 4)),
                r == 1, r == 2);
      end

`ifdef HPF_CAL_MAJORITY_EN
      runCal("noisy_maj", 4, 37, 2, 1'b0, 1'b0);
`endif

      // Comparator never answers: timeout after TIMEOUT request clocks.
      cmp_mode = 3;
      req_high = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
         @(posedge clk); #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("timeout_reached", 32'(ok), 32'd1);
      checkOutput("timeout_cal_err", 32'(cal_err), 32'd1);
      checkOutput("timeout_trim", 32'(trim_code), 32'd32);
      checkOutput("timeout_req", 32'(cmp_req), 32'd0);
      checkOutput("timeout_done", 32'(done), 32'd0);
      checkOutput("timeout_req_cycles", req_high, TIMEOUT);

      // Next start clears the sticky error.
      cmp_mode = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("restart_clears_err", 32'(cal_err), 32'd0);

      // Abort during the third SETTLE phase.
      handshakes = 0;
      wait_n = 0;
      while (handshakes < 2 * HS && wait_n < BUDGET) begin
         @(posedge clk); #1;
         wait_n++;
      end
      checkOutput("abort_reach_settle3", 32'(handshakes >= 2 * HS), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("abort_pre_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_trim", 32'(trim_code), 32'd32);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_req", 32'(cmp_req), 32'd0);
      repeat (150) @(posedge clk);
      #1;
      checkOutput("abort_stays_idle", 32'({busy, cmp_req}), 32'd0);

      // Asynchronous reset in the middle of SAMPLE.
      cmp_mode = 3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
         @(posedge clk); #1;
         if (cmp_req) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("rst_reach_sample", 32'(ok), 32'd1);
      #2;
      rstb = 1'b0;
      #1;
      checkOutput("async_rst_req", 32'(cmp_req), 32'd0);
      checkOutput("async_rst_busy", 32'(busy), 32'd0);
      checkOutput("async_rst_trim", 32'(trim_code), 32'd32);
      @(posedge clk); #1;
      rstb = 1'b1;

      // After a good cal, start together with abort: abort wins.
      runCal("pre_abort", 0, 20, 1, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start_abort_busy", 32'(busy), 32'd0);
      checkOutput("start_abort_done", 32'(done), 32'd0);
      checkOutput("start_abort_trim", 32'(trim_code), 32'd32);
      checkOutput("start_abort_fast", 32'(fast_settle), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
